// File: rtl/interrupt_drain_controller_pkg.sv
// Shared types and constants for the interrupt drain controller.
package InterruptTypes;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    TAKE    = 2'd2,
    RELEASE = 2'd3
  } InterruptDrainState;

  localparam int INT_DRAIN_TIMEOUT_DEFAULT = 1024;
  localparam int IRQ_CODE_MAX_WIDTH        = 8;
  localparam int DRAIN_COUNT_WIDTH         = 16;

  // Fixed-width carriers; the counter covers timeouts up to 65536 cycles.
  typedef logic [IRQ_CODE_MAX_WIDTH-1:0] IrqCodePath;
  typedef logic [DRAIN_COUNT_WIDTH-1:0]  DrainCountPath;

endpackage

// File: rtl/interrupt_drain_controller_encoder.sv
// Combinational lowest-index-first priority encoder over the masked interrupt lines.
module irq_priority_encoder #(
  parameter int NUM_IRQ_SOURCES = 8,
  parameter int IRQ_CODE_WIDTH  = $clog2(NUM_IRQ_SOURCES)
) (
  input  logic [NUM_IRQ_SOURCES-1:0] i_req,
  output logic                       o_valid,
  output logic [IRQ_CODE_WIDTH-1:0]  o_code
);

  assign o_valid = |i_req;

  // Scanning downward lets the lowest set index overwrite any higher one.
  always_comb begin
    o_code = '0;
    for (int i = NUM_IRQ_SOURCES - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_code = IRQ_CODE_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_drain_controller.sv
// Requests NP-stage bubbles for an enabled interrupt, waits for an empty pipeline,
// then presents exactly one interrupt to the CSR/trap unit until it is acknowledged.
module interrupt_drain_controller
  import InterruptTypes::*;
#(
  parameter int NUM_IRQ_SOURCES      = 8,
  parameter int DRAIN_TIMEOUT_CYCLES = INT_DRAIN_TIMEOUT_DEFAULT,
  parameter int IRQ_CODE_WIDTH       = $clog2(NUM_IRQ_SOURCES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_IRQ_SOURCES-1:0] irqPending,
  input  logic [NUM_IRQ_SOURCES-1:0] irqEnable,
  input  logic                       globalIntEnable,
  input  logic                       wholePipelineEmpty,
  input  logic                       cmStageFlushUpper,
  input  logic                       interruptAck,
  output logic                       npStageSendBubbleLowerForInterrupt,
  output logic                       interruptReq,
  output logic [IRQ_CODE_WIDTH-1:0]  interruptCode,
  output logic                       drainTimeout
);

  localparam DrainCountPath CNT_LAST = DrainCountPath'(DRAIN_TIMEOUT_CYCLES - 1);

  logic [NUM_IRQ_SOURCES-1:0] w_masked;
  logic                       w_irq_valid;
  logic [IRQ_CODE_WIDTH-1:0]  w_irq_code;
  logic                       w_eligible;

  InterruptDrainState         r_state;
  DrainCountPath              r_cnt;
  logic [IRQ_CODE_WIDTH-1:0]  r_code_lat;
  logic                       r_bubble;
  logic                       r_req;
  logic [IRQ_CODE_WIDTH-1:0]  r_code;
  logic                       r_timeout;

  InterruptDrainState         w_state_next;
  DrainCountPath              w_cnt_next;
  logic [IRQ_CODE_WIDTH-1:0]  w_code_lat_next;
  logic                       w_timeout_next;

  assign w_masked   = irqPending & irqEnable;
  assign w_eligible = globalIntEnable & w_irq_valid;

  irq_priority_encoder #(
    .NUM_IRQ_SOURCES(NUM_IRQ_SOURCES),
    .IRQ_CODE_WIDTH (IRQ_CODE_WIDTH)
  ) u_irq_priority_encoder (
    .i_req  (w_masked),
    .o_valid(w_irq_valid),
    .o_code (w_irq_code)
  );

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = '0;
    w_code_lat_next = r_code_lat;
    w_timeout_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_eligible) begin
          w_state_next    = DRAIN;
          w_code_lat_next = w_irq_code;
        end
      end
      DRAIN: begin
        w_cnt_next = (r_cnt == CNT_LAST) ? r_cnt : r_cnt + DrainCountPath'(1);
        // A nonzero count proves the bubble was up a full cycle before empty is trusted.
        if (!w_eligible) begin
          w_state_next = IDLE;
        end else if (wholePipelineEmpty && !cmStageFlushUpper && (r_cnt != '0)) begin
          w_state_next = TAKE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next   = IDLE;
          w_timeout_next = 1'b1;
        end
      end
      TAKE: begin
        if (interruptAck) begin
          w_state_next = RELEASE;
        end
      end
      RELEASE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they change in lockstep with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_code_lat <= '0;
      r_bubble   <= 1'b0;
      r_req      <= 1'b0;
      r_code     <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_code_lat <= w_code_lat_next;
      r_bubble   <= (w_state_next == DRAIN) || (w_state_next == TAKE);
      r_req      <= (w_state_next == TAKE);
      r_code     <= (w_state_next == TAKE) ? w_code_lat_next : '0;
      r_timeout  <= w_timeout_next;
    end
  end

  assign npStageSendBubbleLowerForInterrupt = r_bubble;
  assign interruptReq                       = r_req;
  assign interruptCode                      = r_code;
  assign drainTimeout                       = r_timeout;

endmodule

// File: tb/tb_interrupt_drain_controller.sv
// Directed bench for interrupt_drain_controller: default-timeout instance plus a
// second instance with a 4-cycle timeout, sharing one set of inputs.
module tb_interrupt_drain_controller;

  logic       clk;
  logic       rst;
  logic [7:0] irqPending;
  logic [7:0] irqEnable;
  logic       globalIntEnable;
  logic       wholePipelineEmpty;
  logic       cmStageFlushUpper;
  logic       interruptAck;

  logic       bubble;
  logic       req;
  logic [2:0] code;
  logic       tmo;

  logic       bubble4;
  logic       req4;
  logic [2:0] code4;
  logic       tmo4;

  int checks;
  int failures;

  interrupt_drain_controller #(
    .NUM_IRQ_SOURCES     (8),
    .DRAIN_TIMEOUT_CYCLES(1024)
  ) dut (
    .clk                               (clk),
    .rst                               (rst),
    .irqPending                        (irqPending),
    .irqEnable                         (irqEnable),
    .globalIntEnable                   (globalIntEnable),
    .wholePipelineEmpty                (wholePipelineEmpty),
    .cmStageFlushUpper                 (cmStageFlushUpper),
    .interruptAck                      (interruptAck),
    .npStageSendBubbleLowerForInterrupt(bubble),
    .interruptReq                      (req),
    .interruptCode                     (code),
    .drainTimeout                      (tmo)
  );

  interrupt_drain_controller #(
    .NUM_IRQ_SOURCES     (8),
    .DRAIN_TIMEOUT_CYCLES(4)
  ) dut_t4 (
    .clk                               (clk),
    .rst                               (rst),
    .irqPending                        (irqPending),
    .irqEnable                         (irqEnable),
    .globalIntEnable                   (globalIntEnable),
    .wholePipelineEmpty                (wholePipelineEmpty),
    .cmStageFlushUpper                 (cmStageFlushUpper),
    .interruptAck                      (interruptAck),
    .npStageSendBubbleLowerForInterrupt(bubble4),
    .interruptReq                      (req4),
    .interruptCode                     (code4),
    .drainTimeout                      (tmo4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-22s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".bubble"}, 32'(bubble), 32'd0);
    check({tag, ".req"},    32'(req),    32'd0);
    check({tag, ".code"},   32'(code),   32'd0);
    check({tag, ".tmo"},    32'(tmo),    32'd0);
  endtask

  initial begin
    checks             = 0;
    failures           = 0;
    rst                = 1'b1;
    irqPending         = 8'h00;
    irqEnable          = 8'h00;
    globalIntEnable    = 1'b0;
    wholePipelineEmpty = 1'b0;
    cmStageFlushUpper  = 1'b0;
    interruptAck       = 1'b0;

    // Reset state
    step();
    step();
    check_all_zero("reset");
    check("reset.t4.bubble", 32'(bubble4), 32'd0);
    rst = 1'b0;
    step();

    // Basic take: pending bit 3, empty from cycle 3, ack in cycle 6
    irqEnable       = 8'hFF;
    globalIntEnable = 1'b1;
    irqPending      = 8'h08;
    check("t1.c0.bubble", 32'(bubble), 32'd0);
    step();
    check("t1.c1.bubble", 32'(bubble), 32'd1);
    check("t1.c1.req",    32'(req),    32'd0);
    step();
    check("t1.c2.req", 32'(req), 32'd0);
    step();
    wholePipelineEmpty = 1'b1;
    check("t1.c3.req", 32'(req), 32'd0);
    step();
    check("t1.c4.req",    32'(req),    32'd1);
    check("t1.c4.code",   32'(code),   32'd3);
    check("t1.c4.bubble", 32'(bubble), 32'd1);
    step();
    check("t1.c5.req", 32'(req), 32'd1);
    step();
    interruptAck = 1'b1;
    check("t1.c6.code", 32'(code), 32'd3);
    step();
    interruptAck = 1'b0;
    irqPending   = 8'h00;
    check_all_zero("t1.c7");
    step();
    check("t1.c8.bubble", 32'(bubble), 32'd0);
    wholePipelineEmpty = 1'b0;
    step();

    // Priority and no re-arbitration: 0x24 wins bit 2, bit 0 rises during DRAIN
    irqPending = 8'h24;
    step();
    irqPending = 8'h25;
    check("t2.c1.bubble", 32'(bubble), 32'd1);
    step();
    wholePipelineEmpty = 1'b1;
    step();
    check("t2.c3.req",  32'(req),  32'd1);
    check("t2.c3.code", 32'(code), 32'd2);
    interruptAck = 1'b1;
    step();
    interruptAck       = 1'b0;
    irqPending         = 8'h00;
    wholePipelineEmpty = 1'b0;
    check("t2.c4.code", 32'(code), 32'd0);
    step();
    step();

    // Cancel: pending drops two cycles into DRAIN
    irqPending = 8'h01;
    step();
    check("t3.c1.bubble", 32'(bubble), 32'd1);
    step();
    irqPending = 8'h00;
    check("t3.c2.req", 32'(req), 32'd0);
    step();
    check_all_zero("t3.c3");
    step();

    // Flush block: empty high but flush high for cycles 0..2
    irqPending         = 8'h10;
    wholePipelineEmpty = 1'b1;
    cmStageFlushUpper  = 1'b1;
    step();
    step();
    check("t5.c2.req", 32'(req), 32'd0);
    step();
    cmStageFlushUpper = 1'b0;
    check("t5.c3.req",    32'(req),    32'd0);
    check("t5.c3.bubble", 32'(bubble), 32'd1);
    step();
    check("t5.c4.req",  32'(req),  32'd1);
    check("t5.c4.code", 32'(code), 32'd4);
    interruptAck = 1'b1;
    step();
    interruptAck       = 1'b0;
    irqPending         = 8'h00;
    wholePipelineEmpty = 1'b0;
    step();
    step();

    // Reset mid-TAKE, asserted between clock edges
    irqPending         = 8'h02;
    wholePipelineEmpty = 1'b1;
    step();
    step();
    step();
    check("t6.c3.req",  32'(req),  32'd1);
    check("t6.c3.code", 32'(code), 32'd1);
    #3;
    rst        = 1'b1;
    irqPending = 8'h00;
    #1;
    check_all_zero("t6.async");
    step();
    rst          = 1'b0;
    interruptAck = 1'b1;
    step();
    interruptAck = 1'b0;
    check_all_zero("t6.stray_ack");
    irqPending = 8'h02;
    step();
    check("t6.idle_then_drain", 32'(bubble), 32'd1);
    check("t6.no_req",          32'(req),    32'd0);
    irqPending         = 8'h00;
    wholePipelineEmpty = 1'b0;
    step();
    step();

    // Timeout on the 4-cycle instance, empty held low
    irqPending = 8'h40;
    step();
    check("t4.c1.bubble", 32'(bubble4), 32'd1);
    step();
    step();
    step();
    check("t4.c4.bubble", 32'(bubble4), 32'd1);
    check("t4.c4.tmo",    32'(tmo4),    32'd0);
    step();
    check("t4.c5.tmo",    32'(tmo4),    32'd1);
    check("t4.c5.bubble", 32'(bubble4), 32'd0);
    check("t4.c5.req",    32'(req4),    32'd0);
    step();
    check("t4.c6.tmo",    32'(tmo4),    32'd0);
    check("t4.c6.bubble", 32'(bubble4), 32'd1);
    check("t4.main.tmo",  32'(tmo),     32'd0);
    irqPending = 8'h00;
    step();
    check("t4.c7.bubble", 32'(bubble4), 32'd0);
    check("t4.c7.code",   32'(code4),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interrupt_drain_controller.md
Name: interrupt_drain_controller

Overview:
- Drives the interrupt side of the pipeline controller. On an enabled pending interrupt it requests NP-stage bubbles, waits until the whole pipeline is empty, and hands one interrupt to the CSR/trap unit.
- Consumes `wholePipelineEmpty` from the controller and produces `npStageSendBubbleLowerForInterrupt` for it. Sits between the interrupt sources/CSR unit and the pipeline controller.

Parameters:
- `NUM_IRQ_SOURCES`, default 8: number of level-sensitive interrupt lines.
- `DRAIN_TIMEOUT_CYCLES`, default 1024: maximum DRAIN cycles before the attempt is abandoned. Must be ≥ 2.
- `IRQ_CODE_WIDTH`, default `$clog2(NUM_IRQ_SOURCES)`: width of the interrupt code.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `irqPending` in `NUM_IRQ_SOURCES`: level pending bits.
- `irqEnable` in `NUM_IRQ_SOURCES`: per-source enable mask.
- `globalIntEnable` in 1: global interrupt enable (CSR).
- `wholePipelineEmpty` in 1: no live instruction anywhere (from the controller).
- `cmStageFlushUpper` in 1: a recovery flush is in progress.
- `interruptAck` in 1: the CSR unit has taken the trap and redirected the PC.
- `npStageSendBubbleLowerForInterrupt` out 1: bubble request to the NP stage.
- `interruptReq` out 1: take-interrupt request to the CSR unit.
- `interruptCode` out `IRQ_CODE_WIDTH`: index of the interrupt being taken.
- `drainTimeout` out 1: one-cycle pulse when a drain is abandoned.

Behaviour:
- Reset: one clock domain; `rst` is asynchronous and active-high. Reset forces:
  - state to IDLE, drain counter to 0, latched code to 0;
  - every output to 0.
  - Reset asserted mid-operation aborts immediately with the same values, and no ack is expected afterwards.
- `eligible = globalIntEnable & |(irqPending & irqEnable)`.
- Priority: the lowest set index of `irqPending & irqEnable` wins.
- States: IDLE, DRAIN, TAKE, RELEASE. Transitions are evaluated on registered state; outputs are decoded from state.
- IDLE:
  - If `eligible`: latch the winning code, clear the counter, go to DRAIN.
  - Otherwise stay.
- DRAIN:
  - Bubble output = 1. The counter increments each cycle and saturates at `DRAIN_TIMEOUT_CYCLES-1`.
  - Exit priority, highest first:
    1. `!eligible`: go to IDLE (cancel) with no pulse.
    2. `wholePipelineEmpty & !cmStageFlushUpper & counter ≥ 1`: go to TAKE. `counter ≥ 1` guarantees the bubble was asserted for at least one full cycle before empty is trusted.
    3. `counter == DRAIN_TIMEOUT_CYCLES-1`: pulse `drainTimeout` for 1 cycle (registered, visible in the cycle after the decision) and go to IDLE.
  - The latched code is not re-arbitrated during DRAIN, even if a higher-priority source rises.
- TAKE:
  - Bubble = 1, `interruptReq` = 1, `interruptCode` = latched code, all held stable.
  - On `interruptAck`, go to RELEASE.
  - There is no timeout and no cancel in TAKE: the request is committed.
- RELEASE:
  - All outputs 0 for exactly one cycle, then IDLE.
  - This gap gives the CSR unit time to clear `globalIntEnable` before re-evaluation.
- `interruptAck` outside TAKE is ignored.
- `interruptCode` reads 0 in every state except TAKE.
- `cmStageFlushUpper` high in DRAIN only blocks the TAKE transition; counting continues.
- Latency:
  - `eligible` sampled at edge N means the bubble is high from cycle N+1.
  - Earliest `interruptReq` is N+2, requiring empty at N+2 with `counter == 1`.

Decomposition:
- Shared package `InterruptTypes`:
  - `InterruptDrainState` enum (IDLE, DRAIN, TAKE, RELEASE);
  - `IrqCodePath` typedef;
  - `DrainCountPath` typedef;
  - constant `INT_DRAIN_TIMEOUT_DEFAULT`.
- One natural sub-module: `irq_priority_encoder`. It is combinational, lowest-index-first, and outputs a valid bit and the code.

Test Plan:
1. Basic take: `irqEnable=0xFF`, `globalIntEnable=1`, `irqPending=0x08` at cycle 0; `wholePipelineEmpty=1` from cycle 3; ack at cycle 6. Expected: bubble high cycles 1–6; `interruptReq` high cycles 4–6 with `interruptCode=3`; all outputs 0 at cycle 7 (RELEASE), IDLE at cycle 8.
2. Priority and no re-arbitration: `irqPending=0x24`, then bit 0 rises during DRAIN. Expected: `interruptCode=2`.
3. Cancel: pending drops 2 cycles into DRAIN. Expected: bubble falls the next cycle, `drainTimeout=0`, `interruptReq` never asserted.
4. Timeout with `DRAIN_TIMEOUT_CYCLES=4` and `wholePipelineEmpty` held 0. Expected: `drainTimeout` is a 1-cycle pulse after 4 DRAIN cycles, then IDLE; the next DRAIN starts immediately if still eligible.
5. Flush block: empty=1 but `cmStageFlushUpper=1` for 3 cycles. Expected: TAKE is entered only after the flush clears.
6. Reset mid-TAKE with `rst` asserted between clock edges. Expected: all outputs go 0 asynchronously; after reset the state is IDLE; a stray ack is ignored.
